// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the RISC-V
//   core. Owns the PC, runs the instruction-memory request handshake, holds
//   on a hazard stall, follows execute-stage redirects and emits NOP bubbles
//   (addi x0,x0,0) whenever no valid instruction is available.
//
// Handshake: imem_req is raised with a stable imem_addr and kept up until a
//   cycle in which imem_valid=1; that cycle completes the transfer and
//   imem_rdata is sampled on the same rising edge. imem_valid may be high in
//   the very first cycle of a request (zero-wait memory). A started request
//   is never withdrawn, so at most one request is outstanding.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   stall           hazard unit: hold IF/ID and PC
//   redirect_valid  taken branch/jump this cycle (beats stall)
//   redirect_pc     redirect target, bits [1:0] ignored
//   imem_req        fetch request
//   imem_addr       fetch address (the PC register)
//   imem_valid      fetch response valid
//   imem_rdata      fetched instruction
//   instr_out       IF/ID instruction (NOP when instr_valid=0)
//   pc_out          PC of instr_out
//   instr_valid     instr_out is a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   instr_valid
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  // IDLE    : one cycle after reset, no request
  // FETCH   : request up for the current pc
  // HOLD    : response captured in the skid buffer while stalled
  // DISCARD : redirect arrived mid-request; wait out the response and drop it
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    tgt;
  logic [INSTR_WIDTH-1:0] skid_data;
  logic [PC_WIDTH-1:0]    redirect_aligned;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic                   unused_bits;

  assign redirect_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign pc_inc           = pc + PC_WIDTH'(4);
  assign unused_bits      = ^redirect_pc[1:0];

  // In DISCARD pc still holds the old address, so the request stays stable
  // while the redirect target waits in tgt.
  assign imem_req  = (state == FETCH) || (state == DISCARD);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tgt         <= '0;
      skid_data   <= NOP;
      instr_out   <= NOP;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect_valid) begin
            pc          <= redirect_aligned;
            instr_out   <= NOP;
            instr_valid <= 1'b0;
          end
        end

        FETCH: begin
          if (redirect_valid) begin
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            if (imem_valid) begin
              // Response arrives with the redirect: drop it, refetch now.
              pc <= redirect_aligned;
            end else begin
              tgt   <= redirect_aligned;
              state <= DISCARD;
            end
          end else if (imem_valid && !stall) begin
            instr_out   <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
          end else if (imem_valid) begin
            // Stalled: park the response; pc keeps its address for pc_out.
            skid_data <= imem_rdata;
            state     <= HOLD;
          end else if (!stall) begin
            instr_out   <= NOP;
            instr_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            pc          <= redirect_aligned;
            state       <= FETCH;
          end else if (!stall) begin
            instr_out   <= skid_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
            state       <= FETCH;
          end
        end

        DISCARD: begin
          instr_out   <= NOP;
          instr_valid <= 1'b0;
          if (imem_valid) begin
            pc    <= redirect_valid ? redirect_aligned : tgt;
            state <= FETCH;
          end else if (redirect_valid) begin
            tgt <= redirect_aligned;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the RISC-V core; drives the control unit's instruction input (instr_out -> cu instr_in).
- Owns the PC and the instruction-memory request handshake.
- Honours the hazard unit's stall and the execute stage's redirect (taken branch/jump).
- Inserts NOP bubbles (addi x0,x0,0 = 32'h00000013) whenever no valid instruction is available.

Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory address
- INSTR_WIDTH, 32, instruction width (equals `instr_size)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect_valid  in  1  execute stage: taken branch/jump this cycle
- redirect_pc  in  PC_WIDTH  target address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  fetch request; held until imem_valid
- imem_addr  out  PC_WIDTH  fetch address; stable while imem_req=1 and no imem_valid
- imem_valid  in  1  response valid; may assert in the same cycle as imem_req (zero-wait) or later
- imem_rdata  in  INSTR_WIDTH  fetched instruction, valid with imem_valid
- instr_out  out  INSTR_WIDTH  IF/ID instruction to control unit
- pc_out  out  PC_WIDTH  PC of instr_out
- instr_valid  out  1  instr_out is a real instruction (0 = bubble)

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - pc=RESET_PC, state=IDLE, imem_req=0, instr_out=NOP, pc_out=0, instr_valid=0, skid buffer empty.
  - Any outstanding memory response is forgotten.
- FSM states: IDLE, FETCH, HOLD, DISCARD.
- IDLE: imem_req=0. Moves to FETCH on the first edge after reset release.
- FETCH: imem_req=1, imem_addr=pc (combinational from pc register).
  - imem_valid & !stall & !redirect: IF/ID <= {imem_rdata, pc, valid=1}; pc <= pc+4; stay FETCH. Zero-wait memory gives 1 instr/cycle.
  - imem_valid & stall & !redirect: imem_rdata -> skid buffer (with pc); IF/ID holds; go HOLD.
  - !imem_valid & stall: IF/ID and pc hold; request stays up.
  - !imem_valid & !stall: IF/ID <= NOP, instr_valid=0 (bubble).
- HOLD: imem_req=0.
  - While stall=1: IF/ID holds.
  - When stall=0: IF/ID <= skid buffer (valid=1); pc <= pc+4; go FETCH.
- Redirect has priority over stall in every state:
  - IF/ID <= NOP/valid=0; skid buffer dropped.
  - In IDLE, HOLD, or FETCH with imem_valid the same cycle (response dropped): pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; next state FETCH.
  - In FETCH with !imem_valid: tgt <= aligned redirect_pc; go DISCARD.
- DISCARD: imem_req=1, imem_addr=old pc (handshake cannot be aborted).
  - Further redirects overwrite tgt.
  - On imem_valid: response dropped; pc <= tgt; go FETCH. IF/ID outputs NOP/valid=0 throughout.
- Stall with redirect in the same cycle: redirect wins; IF/ID becomes a bubble.
- PC arithmetic: pc+4 modulo 2^PC_WIDTH (wraps from all-ones-minus-3 to 0), no flag.
- Invariants:
  - instr_valid=0 implies instr_out=NOP.
  - pc_out only changes when IF/ID loads.
  - At most one outstanding memory request.

Test Plan:
- Reset release, zero-wait memory returning addr-tagged data -> first instr_valid=1 two edges after rst falls, pc_out=0x0; then pc_out 0x4, 0x8, 0xC on consecutive cycles, instr_out matches data.
- Memory latency 3 cycles -> imem_addr stable for 3 cycles; two NOP bubbles (instr_valid=0) between instructions; one instruction per 3 cycles.
- Stall asserted 2 cycles while response arrives at 0x8 -> instr_out/pc_out (0x4) held; imem_req drops in HOLD; after stall falls, pc_out=0x8 with buffered data, no refetch of 0x8.
- Redirect to 0x103 while a latency-3 fetch of 0x10 is outstanding -> imem_addr stays 0x10 until imem_valid; that data never appears; next request addr=0x100; bubbles meanwhile.
- Redirect and stall in the same cycle -> IF/ID becomes NOP/valid=0 next edge; fetch restarts at the redirect target.
- rst pulsed mid-wait in DISCARD, plus RESET_PC=32'hFFFF_FFF8 -> outputs return to reset values immediately; after release pc_out sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
